// File: rtl/xa_bf_pkg.sv
// Shared definitions for the second-generation beam-forming sequence controller:
// one-hot state encoding, parameter defaults and a state-class helper.
package xa_bf_pkg;

  typedef enum logic [6:0] {
    ST_WAIT_SPEC  = 7'b0000001,
    ST_WAIT_TRANS = 7'b0000010,
    ST_WAIT_RAM0  = 7'b0000100,
    ST_WAIT_RAM1  = 7'b0001000,
    ST_WAIT_CALC  = 7'b0010000,
    ST_END_JUDGE  = 7'b0100000,
    ST_DONE       = 7'b1000000
  } state_e;

  localparam logic [19:0] LP_PAD_SIZE_DEF = 20'd0;
  localparam logic [23:0] LP_TIMEOUT_DEF  = 24'd1000000;

  // States in which the controller waits on an external handshake and the watchdog runs.
  function automatic logic is_wdt_state(input state_e s);
    logic w_res;
    case (s)
      ST_WAIT_TRANS, ST_WAIT_RAM0, ST_WAIT_RAM1, ST_WAIT_CALC: w_res = 1'b1;
      default:                                                 w_res = 1'b0;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/xa_bf_wdt.sv
// Per-state watchdog: counts enabled clocks since the last clear and flags expiry
// on the clock that would make the count reach the limit. A limit of 0 never expires.
module xa_bf_wdt (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [23:0] i_limit,
  output logic        o_expire
);

  logic [23:0] r_cnt;

  // Saturating clock counter, restarted by the owner on every state change.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cnt <= 24'd0;
    end else if (i_enable && (r_cnt != 24'hFFFFFF)) begin
      r_cnt <= r_cnt + 24'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_enable && (i_limit != 24'd0) && (r_cnt == (i_limit - 24'd1));

endmodule

// File: rtl/xa_bf_ctrl_g2.sv
// Beam-forming sequence controller: per frame it drives parameter transfer,
// RAM0/RAM1 loads and P_CALC_NUM calculation passes, with abort and watchdog.
module xa_bf_ctrl_g2
  import xa_bf_pkg::*;
#(
  parameter int          P_FRAME_W  = 4,
  parameter int          P_CALC_NUM = 2,
  parameter logic [19:0] P_PAD_SIZE = LP_PAD_SIZE_DEF,
  parameter logic [23:0] P_TIMEOUT  = LP_TIMEOUT_DEF
) (
  input  logic                 i_clk156m,
  input  logic                 i_srst,
  input  logic [P_FRAME_W-1:0] i_frame_time,
  input  logic                 i_system,
  input  logic                 i_spec_done,
  input  logic                 i_param_end,
  input  logic                 i_ram_done,
  input  logic                 i_calc_end,
  input  logic [31:0]          i_frame_offset,
  output logic                 o_param_start,
  output logic                 o_calc_start,
  output logic                 o_sp_end,
  output logic [19:0]          o_pad_size,
  output logic                 o_end_ins,
  output logic [31:0]          o_frame_offset0,
  output logic [P_FRAME_W-1:0] o_frame_time,
  output logic [4:0]           o_calc_idx,
  output logic                 o_frame_done,
  output logic                 o_abort,
  output logic                 o_timeout,
  output logic [6:0]           o_state
);

  localparam logic [4:0] LP_CALC_NUM = 5'(P_CALC_NUM);
  localparam logic [4:0] LP_LAST_IDX = 5'(P_CALC_NUM - 1);

  state_e                r_state;
  logic [P_FRAME_W-1:0]  r_ft_prev;
  logic [4:0]            r_calc_cnt;

  // First stage of the transition pulses; the output registers form the second stage.
  logic                  r_ev_param_start;
  logic                  r_ev_calc_start;
  logic                  r_ev_sp_end;
  logic                  r_ev_frame_done;
  logic                  r_ev_abort;
  logic                  r_ev_timeout;
  logic [P_FRAME_W-1:0]  r_ev_ft;
  logic [4:0]            r_ev_idx;

  state_e                w_next;
  logic [4:0]            w_cnt_next;
  logic                  w_fchg;
  logic                  w_expire;
  logic                  w_wdt_en;
  logic                  w_wdt_clear;
  logic                  w_ev_param_start;
  logic                  w_ev_calc_start;
  logic                  w_ev_sp_end;
  logic                  w_ev_frame_done;
  logic                  w_ev_abort;
  logic                  w_ev_timeout;

  assign w_fchg      = (i_frame_time != r_ft_prev);
  assign w_wdt_en    = is_wdt_state(r_state);
  assign w_wdt_clear = i_srst || (w_next != r_state) || !w_wdt_en;
  assign o_state     = r_state;

  xa_bf_wdt u_wdt (
    .i_clk    (i_clk156m),
    .i_clear  (w_wdt_clear),
    .i_enable (w_wdt_en),
    .i_limit  (P_TIMEOUT),
    .o_expire (w_expire)
  );

  // Next-state and event decode; frame change outranks the watchdog, which outranks handshakes.
  always_comb begin
    w_next           = r_state;
    w_cnt_next       = r_calc_cnt;
    w_ev_param_start = 1'b0;
    w_ev_calc_start  = 1'b0;
    w_ev_sp_end      = 1'b0;
    w_ev_frame_done  = 1'b0;
    w_ev_abort       = 1'b0;
    w_ev_timeout     = 1'b0;
    if (w_fchg) begin
      w_next = ST_WAIT_SPEC;
      if ((r_state != ST_WAIT_SPEC) && (r_state != ST_DONE)) begin
        w_ev_abort = 1'b1;
      end else begin
        w_ev_abort = 1'b0;
      end
    end else if (w_expire) begin
      w_next       = ST_WAIT_SPEC;
      w_ev_timeout = 1'b1;
    end else begin
      case (r_state)
        ST_WAIT_SPEC: begin
          if (!i_system || i_spec_done) begin
            w_next           = ST_WAIT_TRANS;
            w_ev_param_start = 1'b1;
          end else begin
            w_next = ST_WAIT_SPEC;
          end
        end
        ST_WAIT_TRANS: begin
          if (i_param_end) begin
            w_next      = ST_WAIT_RAM0;
            w_ev_sp_end = i_system;
          end else begin
            w_next = ST_WAIT_TRANS;
          end
        end
        ST_WAIT_RAM0: begin
          if (i_ram_done) begin
            w_next      = ST_WAIT_RAM1;
            w_ev_sp_end = 1'b1;
          end else begin
            w_next = ST_WAIT_RAM0;
          end
        end
        ST_WAIT_RAM1: begin
          if (i_ram_done) begin
            w_next          = ST_WAIT_CALC;
            w_ev_calc_start = 1'b1;
          end else begin
            w_next = ST_WAIT_RAM1;
          end
        end
        ST_WAIT_CALC: begin
          if (i_calc_end) begin
            w_next      = ST_END_JUDGE;
            w_ev_sp_end = 1'b1;
            if (r_calc_cnt != 5'd31) begin
              w_cnt_next = r_calc_cnt + 5'd1;
            end else begin
              w_cnt_next = r_calc_cnt;
            end
          end else begin
            w_next = ST_WAIT_CALC;
          end
        end
        ST_END_JUDGE: begin
          if (r_calc_cnt < LP_CALC_NUM) begin
            w_next = ST_WAIT_RAM0;
          end else begin
            w_next          = ST_DONE;
            w_ev_frame_done = 1'b1;
          end
        end
        ST_DONE: begin
          w_next = ST_DONE;
        end
        default: begin
          w_next = ST_WAIT_SPEC;
        end
      endcase
    end
    if (w_next == ST_WAIT_SPEC) begin
      w_cnt_next = 5'd0;
    end else begin
      w_cnt_next = w_cnt_next;
    end
  end

  // State, counters, pulse pipeline and registered data outputs.
  always_ff @(posedge i_clk156m) begin
    if (i_srst) begin
      r_state          <= ST_WAIT_SPEC;
      r_ft_prev        <= '1;
      r_calc_cnt       <= 5'd0;
      r_ev_param_start <= 1'b0;
      r_ev_calc_start  <= 1'b0;
      r_ev_sp_end      <= 1'b0;
      r_ev_frame_done  <= 1'b0;
      r_ev_abort       <= 1'b0;
      r_ev_timeout     <= 1'b0;
      r_ev_ft          <= '0;
      r_ev_idx         <= 5'd0;
      o_param_start    <= 1'b0;
      o_calc_start     <= 1'b0;
      o_sp_end         <= 1'b0;
      o_frame_done     <= 1'b0;
      o_abort          <= 1'b0;
      o_timeout        <= 1'b0;
      o_frame_time     <= '0;
      o_calc_idx       <= 5'd0;
      o_pad_size       <= 20'd0;
      o_end_ins        <= 1'b0;
      o_frame_offset0  <= 32'd0;
    end else begin
      r_state          <= w_next;
      r_ft_prev        <= i_frame_time;
      r_calc_cnt       <= w_cnt_next;
      r_ev_param_start <= w_ev_param_start;
      r_ev_calc_start  <= w_ev_calc_start;
      r_ev_sp_end      <= w_ev_sp_end;
      r_ev_frame_done  <= w_ev_frame_done;
      r_ev_abort       <= w_ev_abort;
      r_ev_timeout     <= w_ev_timeout;
      if (w_ev_calc_start) begin
        r_ev_ft  <= i_frame_time;
        r_ev_idx <= r_calc_cnt;
      end else begin
        r_ev_ft  <= r_ev_ft;
        r_ev_idx <= r_ev_idx;
      end
      o_param_start <= r_ev_param_start;
      o_calc_start  <= r_ev_calc_start;
      o_sp_end      <= r_ev_sp_end;
      o_frame_done  <= r_ev_frame_done;
      o_abort       <= r_ev_abort;
      o_timeout     <= r_ev_timeout;
      if (r_ev_calc_start) begin
        o_frame_time <= r_ev_ft;
        o_calc_idx   <= r_ev_idx;
      end else begin
        o_frame_time <= o_frame_time;
        o_calc_idx   <= o_calc_idx;
      end
      // Pad/end-code track the state register so they sit exactly on the last pass.
      if ((w_next == ST_WAIT_CALC) && (w_cnt_next == LP_LAST_IDX)) begin
        o_pad_size <= P_PAD_SIZE;
        o_end_ins  <= 1'b1;
      end else begin
        o_pad_size <= 20'd0;
        o_end_ins  <= 1'b0;
      end
      if ((w_next == ST_WAIT_SPEC) && i_system) begin
        o_frame_offset0 <= 32'd0;
      end else begin
        o_frame_offset0 <= i_frame_offset;
      end
    end
  end

endmodule

// File: doc/xa_bf_ctrl_g2.md
# xa_bf_ctrl_g2

Second-generation beam-forming sequence controller for the FA/TA signal-processing chain. It sits between the signal-processing interface and the beam-forming arithmetic core. Per frame it sequences the parameter transfer, the RAM0/RAM1 loads and a parametrised number of calculation passes. Compared with the first-generation controller, it adds:
- a programmable frame-counter width and calculation count;
- abort reporting when a frame changes mid-sequence;
- a per-state watchdog;
- a terminal DONE state, so no pass is repeated within a frame.

## Interface
Parameters:
- P_FRAME_W, 4, width of frame counter (1..8)
- P_CALC_NUM, 2, calculation passes per frame (1..31, any value)
- P_PAD_SIZE, 20'd0, padding amount on last pass
- P_TIMEOUT, 24'd1000000, watchdog limit in clocks per wait state; 0 disables

Ports:
- i_clk156m  in  1  single clock, 156.25 MHz
- i_srst  in  1  reset: synchronous, active-high
- i_frame_time  in  P_FRAME_W  frame counter from the timing generator
- i_system  in  1  1 = TA, 0 = FA; static within a frame
- i_spec_done  in  1  pulse: TA spec-result read complete
- i_param_end  in  1  pulse: sound-speed/position transfer complete
- i_ram_done  in  1  pulse: DDR3 to input-RAM load complete
- i_calc_end  in  1  pulse: one calculation pass complete
- i_frame_offset  in  32  frame offset for RAM0
- o_param_start  out  1  pulse: start parameter transfer
- o_calc_start  out  1  pulse: start calculation pass
- o_sp_end  out  1  pulse: processing-step-complete notification
- o_pad_size  out  20  padding amount; nonzero only on the last pass
- o_end_ins  out  1  end-code insertion; level
- o_frame_offset0  out  32  registered frame offset
- o_frame_time  out  P_FRAME_W  frame number latched at each o_calc_start
- o_calc_idx  out  5  pass index latched at each o_calc_start
- o_frame_done  out  1  pulse: all passes complete
- o_abort  out  1  pulse: sequence aborted by a frame change
- o_timeout  out  1  pulse: watchdog expired
- o_state  out  7  current state, one-hot

## Operation
States are one-hot: WAIT_SPEC, WAIT_TRANS, WAIT_RAM0, WAIT_RAM1, WAIT_CALC, END_JUDGE, DONE.

Frame change (fchg) means i_frame_time differs from its value registered on the previous clock. Its reset value is all-ones.

Transitions:
- WAIT_SPEC → WAIT_TRANS
  - FA: immediately.
  - TA: on i_spec_done.
- WAIT_TRANS → WAIT_RAM0 on i_param_end.
- WAIT_RAM0 → WAIT_RAM1 on i_ram_done.
- WAIT_RAM1 → WAIT_CALC on i_ram_done.
- WAIT_CALC → END_JUDGE on i_calc_end. The same edge increments calc_cnt.
- END_JUDGE:
  - calc_cnt < P_CALC_NUM → WAIT_RAM0.
  - otherwise → DONE, and o_frame_done pulses.
- DONE: holds until fchg, then → WAIT_SPEC.

Abort and watchdog:
- fchg in WAIT_TRANS..END_JUDGE: go to WAIT_SPEC, pulse o_abort, clear calc_cnt.
- fchg in WAIT_SPEC: stay in WAIT_SPEC, no abort.
- Watchdog counts clocks since entry into WAIT_TRANS..WAIT_CALC. At P_TIMEOUT it pulses o_timeout and forces WAIT_SPEC.
- Priority: i_srst > fchg > timeout > normal transition.

Input events:
- Input pulses outside their consuming state are ignored.
- i_calc_end does not count outside WAIT_CALC.

Output pulses:
- o_param_start: on WAIT_SPEC→WAIT_TRANS.
- o_calc_start: on WAIT_RAM1→WAIT_CALC.
- o_sp_end:
  - on WAIT_TRANS→WAIT_RAM0, TA only;
  - on WAIT_RAM0→WAIT_RAM1;
  - on each accepted i_calc_end.

Data outputs:
- o_pad_size and o_end_ins: P_PAD_SIZE and 1 while in WAIT_CALC with calc_cnt == P_CALC_NUM-1; otherwise 0.
- o_frame_offset0: 0 while in WAIT_SPEC with TA; otherwise the registered i_frame_offset.
- calc_cnt is 5 bits and never wraps. It is cleared on entry to WAIT_SPEC.

## Timing
- All outputs are registered.
- Reset values: every output is 0 except o_state = WAIT_SPEC.
- An input pulse sampled at edge k updates o_state at edge k.
- Transition pulses (o_param_start, o_calc_start, o_sp_end on transitions, o_frame_done, o_abort, o_timeout) are high for exactly the cycle following edge k+1.
- o_frame_time and o_calc_idx update together with o_calc_start, and hold until the next one.
- fchg is seen one clock after i_frame_time changes.
- i_srst mid-sequence: all state, counters and outputs return to reset values at the next edge. The watchdog also clears.
- Back-to-back i_ram_done on consecutive clocks advances RAM0 then RAM1. Each state consumes exactly one pulse.

## Structure
- Package xa_bf_pkg holds the state encodings and the default values of P_PAD_SIZE and P_TIMEOUT.
- Sub-module xa_bf_wdt implements the watchdog:
  - inputs: clear, enable, limit;
  - output: expire pulse;
  - 24-bit counter; limit 0 means never expire.

## Test plan
- FA, P_CALC_NUM=3, clean handshakes → 3 o_calc_start with o_calc_idx 0,1,2; o_end_ins high only in pass 2; one o_frame_done; final state DONE.
- TA, P_CALC_NUM=1 → o_sp_end on TRANS→RAM0; o_frame_offset0 = 0 in WAIT_SPEC and equals i_frame_offset afterwards.
- fchg while in WAIT_CALC with calc_cnt=1 → o_abort one cycle; state WAIT_SPEC; calc_cnt 0; no o_frame_done.
- P_TIMEOUT=16, withhold i_param_end → o_timeout 16 clocks after WAIT_TRANS entry; state returns to WAIT_SPEC.
- fchg and timeout on the same clock → o_abort only.
- i_calc_end injected in WAIT_RAM0, then i_srst asserted in WAIT_RAM1 → no count change from the stray pulse; all outputs at reset values one edge after i_srst.
